// File: rtl/adder_9x.sv
// adder_9x: two-stage nine-operand unsigned adder, carry-save tree into one carry-propagate add, result mod 2^N
module adder_9x #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] op1,
    input  logic [N-1:0] op2,
    input  logic [N-1:0] op3,
    input  logic [N-1:0] op4,
    input  logic [N-1:0] op5,
    input  logic [N-1:0] op6,
    input  logic [N-1:0] op7,
    input  logic [N-1:0] op8,
    input  logic [N-1:0] op9,
    output logic [N-1:0] res
);
    function automatic logic [N-1:0] sum3(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
        return a ^ b ^ c;
    endfunction
    // carry bits out of the top position are dropped; only the low N bits of the sum matter
    function automatic logic [N-1:0] cy3(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
        logic [N-1:0] m;
        m = (a & b) | (a & c) | (b & c);
        return m << 1;
    endfunction
    logic [N-1:0] s1a, c1a, s1b, c1b, s1c, c1c;
    logic [N-1:0] s2a, c2a, s2b, c2b;
    logic [N-1:0] s3, c3, s4, c4;
    logic [N-1:0] s_q, c_q;
    assign s1a = sum3(op1, op2, op3);
    assign c1a = cy3(op1, op2, op3);
    assign s1b = sum3(op4, op5, op6);
    assign c1b = cy3(op4, op5, op6);
    assign s1c = sum3(op7, op8, op9);
    assign c1c = cy3(op7, op8, op9);
    assign s2a = sum3(s1a, c1a, s1b);
    assign c2a = cy3(s1a, c1a, s1b);
    assign s2b = sum3(c1b, s1c, c1c);
    assign c2b = cy3(c1b, s1c, c1c);
    assign s3  = sum3(s2a, c2a, s2b);
    assign c3  = cy3(s2a, c2a, s2b);
    assign s4  = sum3(s3, c3, c2b);
    assign c4  = cy3(s3, c3, c2b);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q <= '0;
            c_q <= '0;
            res <= '0;
        end else begin
            s_q <= s4;
            c_q <= c4;
            res <= s_q + c_q;
        end
    end
endmodule

// File: tb/tb_adder_9x.sv
// tb_adder_9x: scoreboard bench driving an 8-bit and a 16-bit adder_9x with shared operands
module tb_adder_9x;
    typedef struct {
        logic [7:0]  e8;
        logic [15:0] e16;
        int          due;
    } exp_t;
    logic        clk = 0;
    logic        rst = 0;
    logic [15:0] ops [9];
    logic [7:0]  res8;
    logic [15:0] res16;
    exp_t        q[$];
    int          cyc = 0;
    int          nchk = 0;
    int          nfail = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    adder_9x #(.N(8)) dut8 (
        .clk(clk), .rst(rst),
        .op1(ops[0][7:0]), .op2(ops[1][7:0]), .op3(ops[2][7:0]),
        .op4(ops[3][7:0]), .op5(ops[4][7:0]), .op6(ops[5][7:0]),
        .op7(ops[6][7:0]), .op8(ops[7][7:0]), .op9(ops[8][7:0]),
        .res(res8)
    );
    adder_9x #(.N(16)) dut16 (
        .clk(clk), .rst(rst),
        .op1(ops[0]), .op2(ops[1]), .op3(ops[2]),
        .op4(ops[3]), .op5(ops[4]), .op6(ops[5]),
        .op7(ops[6]), .op8(ops[7]), .op9(ops[8]),
        .res(res16)
    );
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask
    function automatic exp_t model(input int due);
        exp_t e;
        int s8 = 0;
        int s16 = 0;
        foreach (ops[i]) begin
            s8 += int'(ops[i][7:0]);
            s16 += int'(ops[i]);
        end
        e.e8 = 8'(s8 % 256);
        e.e16 = 16'(s16 % 65536);
        e.due = due;
        return e;
    endfunction
    task automatic go(input int kind, input logic [15:0] v);
        @(negedge clk);
        foreach (ops[i])
            ops[i] = kind == 0 ? v :
                     kind == 1 ? 16'(i + 1) :
                     kind == 2 ? (i == 0 ? 16'd255 : i == 1 ? 16'd1 : 16'd0) :
                     16'($urandom);
        q.push_back(model(cyc + 2));
    endtask
    task automatic do_reset(input int hold, input bit ff);
        exp_t z;
        @(negedge clk);
        rst = 0;
        q.delete();
        #1;
        chk("reset_async8", 16'(res8), 16'd0);
        chk("reset_async16", res16, 16'd0);
        repeat (hold) begin
            @(negedge clk);
            foreach (ops[i]) ops[i] = 16'($urandom);
            #1;
            chk("reset_hold8", 16'(res8), 16'd0);
            chk("reset_hold16", res16, 16'd0);
        end
        #1;
        if (ff) foreach (ops[i]) ops[i] = 16'hFFFF;
        rst = 1;
        z.e8 = 8'd0;
        z.e16 = 16'd0;
        z.due = cyc + 1;
        q.push_back(z);
        q.push_back(model(cyc + 2));
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                if (e.due < cyc) begin
                    chk("missed_slot", 16'(cyc), 16'(e.due));
                end else begin
                    chk("res8", 16'(res8), 16'(e.e8));
                    chk("res16", res16, e.e16);
                end
            end
        end
    end
    initial begin
        foreach (ops[i]) ops[i] = 16'($urandom);
        do_reset(3, 1'b1);
        go(0, 16'hFFFF);
        go(0, 16'd0);
        go(0, 16'd0);
        go(0, 16'd1);
        go(0, 16'd1);
        go(0, 16'd29);
        go(2, 16'd0);
        go(1, 16'd0);
        go(0, 16'h10);
        go(0, 16'h80);
        go(0, 16'hFFFF);
        go(3, 16'd0);
        go(3, 16'd0);
        do_reset(0, 1'b0);
        go(3, 16'd0);
        go(3, 16'd0);
        go(3, 16'd0);
        do_reset(2, 1'b0);
        for (int n = 0; n < 10000; n++) go(3, 16'd0);
        repeat (4) @(negedge clk);
        chk("queue_drained", 16'(q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/adder_9x.md
Name: adder_9x

Overview:
- Pipelined nine-operand unsigned adder.
- Sums nine N-bit operands every clock and returns the sum truncated to N bits, two cycles later.
- Built as a carry-save (3:2 compressor) reduction tree followed by one carry-propagate adder.
- Intended as a reusable datapath primitive, e.g. 3x3 window/kernel accumulation.

Parameters:
- N, 8, width in bits of every operand and of the result; legal for N >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; clears all pipeline state while low.
- op1  input  N  operand 1, unsigned.
- op2  input  N  operand 2, unsigned.
- op3  input  N  operand 3, unsigned.
- op4  input  N  operand 4, unsigned.
- op5  input  N  operand 5, unsigned.
- op6  input  N  operand 6, unsigned.
- op7  input  N  operand 7, unsigned.
- op8  input  N  operand 8, unsigned.
- op9  input  N  operand 9, unsigned.
- res  output N  registered result, (op1+...+op9) mod 2^N.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-low. No handshake or enable; a new operand set is accepted every cycle (throughput 1/cycle).
- Arithmetic:
  - All operands are unsigned.
  - The exact sum needs N+4 bits.
  - res carries only the low N bits; bits N and above are discarded (wrap-around, no saturation, no overflow flag).
- Stage 1 (combinational reduction, then register):
  - Level 1: three 3:2 compressors reduce op1..op9 to 6 vectors.
  - Level 2: two compressors reduce to 4 vectors.
  - Level 3: one compressor reduces to 3 vectors.
  - Level 4: one compressor reduces to 2 vectors (sum S, carry C).
  - Carry vectors are shifted left by 1. All intermediate vectors are truncated to N bits, since only the result modulo 2^N is required.
  - S and C are captured in N-bit stage-1 registers on the rising clk edge.
- Stage 2: the N-bit carry-propagate adder computes S+C mod 2^N, captured in the res register on the rising clk edge.
- Latency: operands applied before rising edge k appear on res after rising edge k+1 (2 cycles), valid until edge k+2.
- Reset:
  - While rst=0, the stage-1 registers and res are forced to 0 immediately, independent of clk.
  - Release is synchronous to the next edge. After rst rises, the first edge loads stage 1 with the current operands while res loads 0+0=0. The true sum appears on res after the second edge.
- Reset asserted mid-operation: in-flight sums are lost, and res goes to 0 without waiting for a clock edge.
- Operand changes between edges have no effect on res until they propagate through both register stages.
- No X propagation from reset: every flop has a defined reset value of 0.

Test Plan:
- Reset: hold rst=0 with arbitrary operands and toggle clk -> res stays 0. Release rst, all ops=8'hFF -> res=0 after edge 1 and 8'hF7 after edge 2 (2295 mod 256).
- Zero/one: all ops=0 -> res=0. Then op1..op9=1 -> res=9 exactly two edges later.
- Wrap: op1..op9 = 8'd29 (sum 261) -> res=8'd5. Also op1=8'd255, op2=8'd1, others 0 -> res=0.
- Pipelining: change operands every cycle with sequence A=(1..9, sum 45), B=(all 8'h10, sum 144), C=(all 8'h80, sum 1152 mod 256 = 128) -> res is 45, 144, 128 on consecutive edges, starting 2 edges after A.
- Async reset mid-stream: pulse rst low between edges while pipeline is full -> res drops to 0 immediately. After release, the first valid sum appears 2 edges later.
- Random: 10k random operand sets with N=8 and N=16, compared against the reference sum mod 2^N with a 2-cycle delay.
